// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider slice.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Iteration counter width; holds values up to WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/restoring_divider_sub_stage.sv
// Subtract-with-borrow stage: diff = a - b at full width, bor flags a < b.
module sub_stage #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           bor
);

  assign diff = a + ~b + (WIDTH+1)'(1);
  assign bor  = (a < b);

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle,
// with a start/busy/done handshake.
module restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t state, state_nx;

  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic             bor;
  logic [WIDTH:0]   r_nx;
  logic [WIDTH-1:0] q_nx;

  // Shift the next dividend bit into the partial remainder.
  assign r_sh = (r << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};

  sub_stage #(.WIDTH(WIDTH)) u_sub (
    .a    (r_sh),
    .b    ({1'b0, dvs}),
    .diff (diff),
    .bor  (bor)
  );

  assign r_nx = bor ? r_sh : diff;
  assign q_nx = (q << 1) | {{(WIDTH-1){1'b0}}, ~bor};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (divisor == '0) ? DONE : RUN;
      RUN:     if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd         <= '0;
      dvs         <= '0;
      r           <= '0;
      q           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd         <= dividend;
            dvs         <= divisor;
            r           <= '0;
            q           <= '0;
            cnt         <= CW'(WIDTH - 1);
            div_by_zero <= (divisor == '0);
            // Divide-by-zero skips RUN, so its results are loaded here.
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        RUN: begin
          dvd <= dvd << 1;
          r   <= r_nx;
          q   <= q_nx;
          if (cnt == '0) begin
            quotient  <= q_nx;
            remainder <= r_nx[WIDTH-1:0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench: timeline/arithmetic model of the divider plus
// directed literal cases, a full operand sweep and random traffic.
module tb_restoring_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each accepted request is scheduled on an edge
  // timeline and its result comes from plain division.
  int e = 0;
  int acc_e = 0;
  int done_e = 0;
  int free_e = 0;
  bit have_job = 0;
  int pq = 0, pr = 0, pdz = 0;
  int hq = 0, hr = 0, hdz = 0;
  int model_dones = 0;
  int dut_dones = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      have_job = 0;
      free_e   = 0;
      hq = 0; hr = 0; hdz = 0;
    end else begin
      e = e + 1;
      if (start === 1'b1 && e >= free_e) begin
        int a, b, lat;
        a = int'(dividend);
        b = int'(divisor);
        if (b == 0) begin
          pq = (1 << W) - 1; pr = a; pdz = 1; lat = 0;
        end else begin
          pq = a / b; pr = a % b; pdz = 0; lat = W;
        end
        acc_e    = e;
        done_e   = e + lat;
        free_e   = done_e + 2;
        have_job = 1;
        hdz      = 0;
      end
      if (have_job && e == done_e) begin
        hq = pq; hr = pr; hdz = pdz;
        model_dones++;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_busy, exp_done;
    exp_busy = have_job && e >= acc_e && e <= done_e;
    exp_done = have_job && e == done_e;
    chk("busy", int'(busy), int'(exp_busy));
    chk("done", int'(done), int'(exp_done));
    chk("div_by_zero", int'(div_by_zero), hdz);
    if (!exp_busy || exp_done) begin
      chk("quotient", int'(quotient), hq);
      chk("remainder", int'(remainder), hr);
    end
    if (done === 1'b1) dut_dones++;
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_timeout"}, int'(busy === 1'b0), 1);
  endtask

  task automatic run_one(input string nm, input int a, input int b,
                         input int eq, input int er, input int edz, input int elat);
    int n, bc;
    wait_idle(nm);
    @(negedge clk); #1;
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; bc = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (busy === 1'b1) bc++;
      if (done === 1'b1) break;
    end
    chk({nm, "_done_seen"}, int'(done === 1'b1), 1);
    chk({nm, "_latency"}, n, elat);
    chk({nm, "_busy_cycles"}, bc, elat);
    chk({nm, "_quotient"}, int'(quotient), eq);
    chk({nm, "_remainder"}, int'(remainder), er);
    chk({nm, "_dz"}, int'(div_by_zero), edz);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, n, idx, guard;
    bit pb;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_dz", int'(div_by_zero), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_one("d13_3", 13, 3, 4, 1, 0, 5);
    run_one("d7_9", 7, 9, 0, 7, 0, 5);
    run_one("d15_1", 15, 1, 15, 0, 0, 5);
    run_one("d15_15", 15, 15, 1, 0, 0, 5);
    run_one("d0_5", 0, 5, 0, 0, 0, 5);
    run_one("d11_0", 11, 0, 15, 11, 1, 1);
    run_one("d8_2", 8, 2, 4, 0, 0, 5);

    // Starts during RUN and during DONE must be ignored.
    wait_idle("busy_start");
    @(negedge clk); #1;
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 4'd9; divisor = 4'd3;
    @(negedge clk); @(negedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = 0; n = 0;
    while (n < 20 && d0 == 0) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) d0++;
    end
    chk("busy_start_quotient", int'(quotient), 2);
    chk("busy_start_remainder", int'(remainder), 2);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) d0++;
    end
    chk("busy_start_done_count", d0, 1);
    chk("busy_start_final_q", int'(quotient), 2);

    // Asynchronous reset mid-run.
    wait_idle("rst_mid");
    @(negedge clk); #1;
    dividend = 4'd14; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_quotient", int'(quotient), 0);
    chk("rst_mid_remainder", int'(remainder), 0);
    chk("rst_mid_dz", int'(div_by_zero), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    run_one("d14_3", 14, 3, 4, 2, 0, 5);

    // Full sweep with start held high; next operands presented once accepted.
    wait_idle("sweep");
    @(negedge clk); #1;
    dividend = 4'd0; divisor = 4'd1; start = 1'b1;
    idx = 0; guard = 0;
    while (idx < 240 && guard < 3000) begin
      @(negedge clk);
      pb = busy;
      @(posedge clk); #1;
      guard++;
      if (!pb && busy === 1'b1) begin
        idx++;
        dividend = W'(idx / 15);
        divisor  = W'(idx % 15 + 1);
      end
    end
    start = 1'b0;
    chk("sweep_requests", idx, 240);

    // Random traffic, including zero divisors and starts while busy.
    wait_idle("random");
    repeat (600) begin
      @(negedge clk); #1;
      start    = ($urandom_range(2, 0) != 0);
      dividend = W'($urandom);
      divisor  = ($urandom_range(4, 0) == 0) ? '0 : W'($urandom);
    end
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle("random_end");
    repeat (3) @(negedge clk);

    chk("done_count", dut_dones, model_dones);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
Sequential unsigned restoring divider built on the team's subtract-with-borrow stage. Each cycle it produces one quotient bit: it subtracts the divisor from the partial remainder and uses the borrow to choose between keeping the difference and restoring the remainder. The block sits directly downstream of the subtractor and consumes its diff/borrow pair. A start/busy/done handshake connects it to a controller or testbench.

Parameters:
WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder (legal range 2..16).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend; captured when start is accepted
divisor  input  WIDTH  unsigned divisor; captured when start is accepted
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  WIDTH  unsigned quotient
remainder  output  WIDTH  unsigned remainder
div_by_zero  output  1  high with done when the captured divisor was 0; held until next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal counter and registers cleared. An operation in flight is abandoned with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge → capture dividend and divisor, clear the partial remainder R (WIDTH+1 bits) and the quotient shift register Q, set count=WIDTH-1, go to RUN.
  - If the captured divisor==0 → go to DONE instead, with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
- RUN, one iteration per cycle:
  - R_sh = {R[WIDTH-1:0], D[MSB]}; shift D left by 1.
  - Trial subtraction: {diff, bor} = R_sh - {0, divisor}, computed at WIDTH+1 bits.
  - bor=1 → R=R_sh, shift 0 into Q. bor=0 → R=diff, shift 1 into Q.
  - count==0 → go to DONE; otherwise decrement count.
- DONE (exactly one cycle): done=1; quotient=Q; remainder=R[WIDTH-1:0]; then go to IDLE.
- Latency: start accepted at edge k → done high during cycle k+WIDTH+1. For divide-by-zero, done is high during cycle k+1.
- quotient, remainder and div_by_zero hold their values in IDLE until the next accepted start. busy=0 in IDLE.
- start while busy=1 is ignored, including start during the DONE cycle. start held high continuously restarts on the first IDLE edge after DONE. Operand changes while busy have no effect.
- Arithmetic: R never exceeds 2*divisor-1, so WIDTH+1 bits suffice. The result must satisfy dividend == quotient*divisor + remainder and remainder < divisor.
- Boundaries:
  - dividend < divisor → quotient=0, remainder=dividend.
  - dividend==0 → 0/0 remainder.
  - divisor==1 → quotient=dividend, remainder=0.
  - dividend=divisor=all ones → 1 remainder 0.

Decomposition:
- Shared package div_pkg holds:
  - state enum typedef (IDLE, RUN, DONE);
  - the default width constant;
  - the count-width localparam function, $clog2(WIDTH).
- One sub-module, sub_stage: combinational, WIDTH+1-bit a, b → diff, bor. bor=1 iff a<b; diff = a + ~b + 1. Instantiated once in the datapath.
- FSM, counter and shift registers stay in restoring_divider.

Test Plan:
- Reset, then start with dividend=13, divisor=3 → done exactly 5 cycles after the start edge; quotient=4, remainder=1, div_by_zero=0; busy high for 5 cycles.
- 7/9 → quotient=0, remainder=7. 15/1 → quotient=15, remainder=0. 15/15 → 1, 0. 0/5 → 0, 0.
- Divisor=0, dividend=11 → done 1 cycle after start; div_by_zero=1, quotient=4'b1111, remainder=11. The next valid start (8/2) clears div_by_zero and gives 4, 0.
- start 12/5 accepted, then start pulses with 9/3 during RUN and during DONE → a single done with 2, 2; 9/3 is never computed.
- Assert rst two cycles into a 14/3 run → all outputs 0 immediately (async) and no done pulse. After release, 14/3 gives 4, 2.
- Exhaustive sweep: all 16×16 pairs with divisor≠0, back-to-back starts → every result matches a/b and a%b; done count equals the number of requests.
